// File: rtl/memwrite_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : memwrite_monitor
//  Purpose  : Bus-side monitor on the CPU store path. Logs accepted stores in
//             a first-word-fall-through FIFO and counts them. Flags pass on
//             the signature store, or fail when the watchdog expires first.
//  Revision : 1.0  initial release
// ============================================================================
module memwrite_monitor #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 8,
  parameter int               AW        = 3,
  parameter logic [WIDTH-1:0] PASS_ADR  = 'h4,
  parameter logic [WIDTH-1:0] PASS_DATA = 'h7,
  parameter int               TIMEOUT   = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  input  logic             log_rd,
  output logic             log_valid,
  output logic [WIDTH-1:0] log_adr,
  output logic [WIDTH-1:0] log_data,
  output logic             log_overflow,
  output logic [15:0]      wr_count,
  output logic             done,
  output logic             pass,
  output logic             fail
);

  // Watchdog only ever holds 0..TIMEOUT-1; it stops before reaching TIMEOUT.
  localparam int            c_WDW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [c_WDW-1:0] c_WD_LAST = c_WDW'(TIMEOUT - 1);
  localparam logic [c_WDW-1:0] c_WD_ONE  = c_WDW'(1);
  localparam logic [AW:0]   c_FULL      = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] c_PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [c_WDW-1:0] r_wdog;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic [15:0]      r_wr_count;
  logic [WIDTH-1:0] r_mem_adr  [DEPTH];
  logic [WIDTH-1:0] r_mem_data [DEPTH];

  logic w_accept;
  logic w_sig;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_accept = memwrite && (r_state == ST_RUN);
  assign w_sig    = w_accept && (adr == PASS_ADR) && (writedata == PASS_DATA);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_FULL);
  assign w_pop    = log_rd && !w_empty;
  // A full FIFO still accepts a push when the same edge frees a slot.
  assign w_push   = w_accept && (!w_full || w_pop);
  assign w_drop   = w_accept && w_full && !w_pop;

  // Next-state decode and status outputs; signature wins over watchdog expiry.
  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    pass        = 1'b0;
    fail        = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_sig) begin
          w_state_nxt = ST_PASS;
        end else if (r_wdog == c_WD_LAST) begin
          w_state_nxt = ST_FAIL;
        end
      end
      ST_PASS: begin
        done = 1'b1;
        pass = 1'b1;
      end
      ST_FAIL: begin
        done = 1'b1;
        fail = 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // FSM state register and watchdog; watchdog freezes once a verdict is reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) begin
        r_wdog <= r_wdog + c_WD_ONE;
      end
    end
  end

  // FIFO pointers, occupancy, sticky overflow and saturating store counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_wr_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_accept && (r_wr_count != 16'hFFFF)) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

  // Log storage; contents are only visible while the entry is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_adr[r_wr_ptr]  <= adr;
      r_mem_data[r_wr_ptr] <= writedata;
    end
  end

  assign log_valid    = !w_empty;
  assign log_adr      = w_empty ? '0 : r_mem_adr[r_rd_ptr];
  assign log_data     = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign log_overflow = r_overflow;
  assign wr_count     = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_memwrite_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memwrite_monitor
//  Purpose  : Self-checking bench for memwrite_monitor: vector table, directed
//             corner sequences and randomized runs against a queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_memwrite_monitor;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        log_rd;
  logic        log_valid;
  logic [31:0] log_adr;
  logic [31:0] log_data;
  logic        log_overflow;
  logic [15:0] wr_count;
  logic        done;
  logic        pass;
  logic        fail;

  int checks   = 0;
  int failures = 0;

  memwrite_monitor #(
    .WIDTH(32), .DEPTH(DEPTH), .AW(3),
    .PASS_ADR(32'h4), .PASS_DATA(32'h7), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .adr(adr),
    .writedata(writedata), .log_rd(log_rd), .log_valid(log_valid),
    .log_adr(log_adr), .log_data(log_data), .log_overflow(log_overflow),
    .wr_count(wr_count), .done(done), .pass(pass), .fail(fail)
  );

  always #5 clk = ~clk;

  // Observation word: {valid, adr, data, overflow, count, done, pass, fail}
  typedef logic [84:0] obs_t;

  function automatic obs_t mk(logic v, logic [31:0] a, logic [31:0] d, logic ov,
                              logic [15:0] c, logic dn, logic p, logic f);
    return {v, a, d, ov, c, dn, p, f};
  endfunction

  function automatic obs_t obs();
    return mk(log_valid, log_adr, log_data, log_overflow, wr_count, done, pass, fail);
  endfunction

  task automatic chk(input string nm, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got v=%b a=%h d=%h ov=%b cnt=%0d dpf=%b%b%b want v=%b a=%h d=%h ov=%b cnt=%0d dpf=%b%b%b",
               nm, act[84], act[83:52], act[51:20], act[19], act[18:3], act[2], act[1], act[0],
               exp[84], exp[83:52], exp[51:20], exp[19], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Apply inputs for one rising edge, return at the following falling edge idle.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic rd);
    memwrite  = mw;
    adr       = a;
    writedata = d;
    log_rd    = rd;
    @(posedge clk);
    @(negedge clk);
    memwrite  = 1'b0;
    adr       = '0;
    writedata = '0;
    log_rd    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    memwrite = 1'b0; adr = '0; writedata = '0; log_rd = 1'b0;
    @(negedge clk);
    chk("reset_state", obs(), '0);
    reset = 1'b1;
  endtask

  typedef struct {
    logic        mw;
    logic [31:0] a;
    logic [31:0] d;
    logic        rd;
    obs_t        exp;
  } vec_t;

  vec_t tbl[10];

  // Reference model state
  logic [63:0] m_q[$];
  int          m_st;      // 0 running, 1 passed, 2 failed
  int          m_edges;
  logic        m_ovf;
  int          m_cnt;

  task automatic model_edge(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic rd);
    bit acc;
    bit popped;
    int size_pre;
    acc      = mw && (m_st == 0);
    size_pre = m_q.size();
    popped   = rd && (size_pre > 0);
    if (popped) void'(m_q.pop_front());
    if (acc) begin
      if (size_pre < DEPTH || popped) m_q.push_back({a, d});
      else m_ovf = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
    if (m_st == 0) begin
      if (acc && a == 32'h4 && d == 32'h7) m_st = 1;
      else if (m_edges == TIMEOUT - 1) m_st = 2;
      m_edges++;
    end
  endtask

  function automatic obs_t model_obs();
    logic [63:0] h;
    h = (m_q.size() > 0) ? m_q[0] : 64'h0;
    return mk(m_q.size() > 0, h[63:32], h[31:0], m_ovf, 16'(m_cnt),
              m_st != 0, m_st == 1, m_st == 2);
  endfunction

  initial begin
    reset = 1'b0; memwrite = 1'b0; adr = '0; writedata = '0; log_rd = 1'b0;

    // Basic logging, popping and signature pass
    tbl[0] = '{1'b1, 32'h10, 32'hA1, 1'b0, mk(1, 32'h10, 32'hA1, 0, 16'd1, 0, 0, 0)};
    tbl[1] = '{1'b1, 32'h14, 32'hA2, 1'b0, mk(1, 32'h10, 32'hA1, 0, 16'd2, 0, 0, 0)};
    tbl[2] = '{1'b1, 32'h18, 32'hA3, 1'b0, mk(1, 32'h10, 32'hA1, 0, 16'd3, 0, 0, 0)};
    tbl[3] = '{1'b0, 32'h0,  32'h0,  1'b1, mk(1, 32'h14, 32'hA2, 0, 16'd3, 0, 0, 0)};
    tbl[4] = '{1'b0, 32'h0,  32'h0,  1'b1, mk(1, 32'h18, 32'hA3, 0, 16'd3, 0, 0, 0)};
    tbl[5] = '{1'b0, 32'h0,  32'h0,  1'b1, mk(0, 32'h0,  32'h0,  0, 16'd3, 0, 0, 0)};
    tbl[6] = '{1'b0, 32'h0,  32'h0,  1'b1, mk(0, 32'h0,  32'h0,  0, 16'd3, 0, 0, 0)};
    tbl[7] = '{1'b1, 32'h4,  32'h7,  1'b0, mk(1, 32'h4,  32'h7,  0, 16'd4, 1, 1, 0)};
    tbl[8] = '{1'b1, 32'h8,  32'h9,  1'b0, mk(1, 32'h4,  32'h7,  0, 16'd4, 1, 1, 0)};
    tbl[9] = '{1'b0, 32'h0,  32'h0,  1'b1, mk(0, 32'h0,  32'h0,  0, 16'd4, 1, 1, 0)};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].mw, tbl[i].a, tbl[i].d, tbl[i].rd);
      chk($sformatf("table[%0d]", i), obs(), tbl[i].exp);
    end

    // Watchdog expiry with no stores
    do_reset();
    for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, '0, '0, 1'b0);
    chk("wdog_before_expiry", obs(), mk(0, 0, 0, 0, 16'd0, 0, 0, 0));
    step(1'b0, '0, '0, 1'b0);
    chk("wdog_expired", obs(), mk(0, 0, 0, 0, 16'd0, 1, 0, 1));
    step(1'b1, 32'h4, 32'h7, 1'b0);
    chk("store_after_fail", obs(), mk(0, 0, 0, 0, 16'd0, 1, 0, 1));

    // Signature store exactly on the expiry edge
    do_reset();
    for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, '0, '0, 1'b0);
    step(1'b1, 32'h4, 32'h7, 1'b0);
    chk("sig_on_expiry", obs(), mk(1, 32'h4, 32'h7, 0, 16'd1, 1, 1, 0));

    // Overflow: 10 stores into 8 entries, then drain
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 32'h100 + 32'(4 * i), 32'hD0 + 32'(i), 1'b0);
    chk("overflow_fill", obs(), mk(1, 32'h100, 32'hD0, 1, 16'd10, 0, 0, 0));
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, '0, '0, 1'b1);
      if (k < 8) chk($sformatf("overflow_pop%0d", k), obs(),
                     mk(1, 32'h100 + 32'(4 * k), 32'hD0 + 32'(k), 1, 16'd10, 0, 0, 0));
      else       chk("overflow_drained", obs(), mk(0, 0, 0, 1, 16'd10, 0, 0, 0));
    end

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 32'h200 + 32'(4 * i), 32'hE0 + 32'(i), 1'b0);
    step(1'b1, 32'h300, 32'hEE, 1'b1);
    chk("full_push_pop", obs(), mk(1, 32'h204, 32'hE1, 0, 16'd9, 0, 0, 0));
    for (int j = 1; j <= 8; j++) begin
      step(1'b0, '0, '0, 1'b1);
      if (j < 7)       chk($sformatf("pp_pop%0d", j), obs(),
                           mk(1, 32'h204 + 32'(4 * j), 32'hE1 + 32'(j), 0, 16'd9, 0, 0, 0));
      else if (j == 7) chk("pp_newest", obs(), mk(1, 32'h300, 32'hEE, 0, 16'd9, 0, 0, 0));
      else             chk("pp_empty", obs(), mk(0, 0, 0, 0, 16'd9, 0, 0, 0));
    end

    // Asynchronous reset between edges
    do_reset();
    step(1'b1, 32'h40, 32'hC1, 1'b0);
    step(1'b1, 32'h44, 32'hC2, 1'b0);
    step(1'b1, 32'h4,  32'h7,  1'b0);
    chk("pre_async_reset", obs(), mk(1, 32'h40, 32'hC1, 0, 16'd3, 1, 1, 0));
    #2 reset = 1'b0;
    #1 chk("async_reset_clear", obs(), '0);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("after_release_idle", obs(), '0);
    step(1'b1, 32'h20, 32'hB1, 1'b0);
    chk("resume_store", obs(), mk(1, 32'h20, 32'hB1, 0, 16'd1, 0, 0, 0));

    // Randomized runs against the queue model
    for (int s = 0; s < 20; s++) begin
      do_reset();
      m_q.delete(); m_st = 0; m_edges = 0; m_ovf = 1'b0; m_cnt = 0;
      for (int c = 0; c < 30; c++) begin
        logic        mw, rd;
        logic [31:0] a, d;
        mw = ($urandom_range(0, 99) < 60);
        rd = ($urandom_range(0, 99) < 35);
        a  = 32'($urandom_range(0, 3) * 4);
        d  = 32'($urandom_range(5, 8));
        model_edge(mw, a, d, rd);
        step(mw, a, d, rd);
        chk($sformatf("rand_s%0d_c%0d", s, c), obs(), model_obs());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
